switch_nport: RTL and testbench
===============================

# switch_nport

Parametrised N-port packet switch: the successor of the fixed 4-port switch. Each input port has its own packet FIFO. Each output port has a round-robin arbiter and a registered output stage with downstream backpressure. Multicast targets are supported: one packet is delivered to every output whose bit is set in its target field. The block sits between the port-side packet sources and sinks and replaces the 4-port switch top.

## Interface
Parameters:
- NUM_PORTS, 4, number of ports N (≥2); source/target fields are N-bit one-hot/multi-hot masks
- DATA_WIDTH, 8, payload width DW
- FIFO_DEPTH, 4, packets per input FIFO (power of two, ≥2)

Ports (vectors flattened, port p occupies slice p):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  N  input packet valid per port
- ready_in  out  N  input port can accept; = FIFO not full
- source_in  in  N*N  source mask per input port
- target_in  in  N*N  target mask per input port (multi-hot = multicast)
- data_in  in  N*DW  payload per input port
- valid_out  out  N  output register valid per port
- ready_out  in  N  downstream accepts output packet
- source_out  out  N*N  source field of delivered packet
- target_out  out  N*N  original target field of delivered packet
- data_out  out  N*DW  payload of delivered packet

## Operation
- Ingress: a packet is accepted on port p when valid_in[p] && ready_in[p]. ready_in[p] = !full[p]. A push is refused when the FIFO is full even if the FIFO pops in the same cycle.
- Packets with target==0 are accepted (the handshake completes) but never written to the FIFO.
- Each FIFO keeps a pending mask rem[p] of outputs not yet served by its head packet. rem[p] loads the head target when a new head appears.
- Request: input i requests output o when FIFO i is non-empty and rem[i][o]==1.
- Output o is free when !valid_out[o] || ready_out[o].
- Arbiter o grants only when output o is free. It grants the first requester at or after pointer ptr[o], searching upward and wrapping modulo N.
- On a grant to input i, ptr[o] becomes (i+1) mod N. With no grant, ptr[o] is unchanged. Pointer width is $clog2(N).
- One head packet may be granted to several outputs in the same cycle. Every granted bit is cleared from rem[i].
- When rem[i] would become 0, FIFO i pops, and the next head's target loads into rem[i] in the same edge. Consecutive packets therefore issue with no bubble.
- A granted packet loads output register o: valid_out[o]=1, with source/target/data taken verbatim from the head. target_out keeps the full original mask.
- The output register holds its contents while valid_out[o] && !ready_out[o].
- It clears (valid_out[o]=0) when ready_out[o]=1 and there is no new grant.
- A packet whose target includes its own source port is delivered normally, with no loopback filtering.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - all FIFOs empty and rem=0
  - ptr[o]=0
  - valid_out=0, source_out=0, target_out=0, data_out=0
  - ready_in=all ones (combinational from empty)
- Reset asserted mid-operation discards all buffered and in-flight packets immediately.
- Latency:
  - accepted at edge t → head visible and arbitrated in cycle t+1 → valid_out at edge t+2, given no contention and a free output
  - contention adds one cycle per earlier winner on that output
- Throughput: one packet per output per cycle. One head packet per input completes per cycle when all its targets are granted together.
- A stalled output (ready_out=0) blocks only the heads that target it; other outputs keep flowing. The head-of-line input stays stalled until its rem clears.
- Boundaries:
  - FIFO full: ready_in=0 the next cycle, and it rises the cycle after a pop.
  - Pointer wraps from N-1 to 0.
  - Simultaneous requests from all N inputs to one output are served in N consecutive cycles, in rotating order.

## Test plan
- Unicast, N=4, idle: port 0 sends target=4'b0100, data=8'hA5 → port 2 valid_out=1 exactly 2 cycles after acceptance with data 8'hA5, source 4'b0001, target 4'b0100. No other valid_out.
- Contention: ports 0–3 all send target=4'b1000 in one cycle, ready_out=1 → port 3 delivers sources 0,1,2,3 on 4 consecutive cycles. A second identical burst delivers in order 0,1,2,3 again (ptr wrapped to 0).
- Multicast with stall: port 1 sends target=4'b1101, ready_out[2]=0 (unused), ready_out[3]=0 for 3 cycles → ports 0 and 2 deliver at t+2. Port 3 output register holds the packet until ready_out[3] rises. FIFO 1 pops only after the port-3 grant.
- Backpressure/full: ready_out[0]=0, port 2 pushes 6 packets to output 0 with FIFO_DEPTH=4 → ready_in[2] drops after 5 accepted (4 in FIFO, 1 in output register). Releasing ready_out[0] delivers all, in order, with no loss or duplication.
- Drop: target=0 on port 3 → ready_in[3]=1, no valid_out ever, FIFO 3 stays empty.
- Reset mid-traffic: assert rst while 3 packets are buffered → valid_out=0 and ready_in=4'b1111 asynchronously. After release no stale packet emerges, and ptr restarts at 0.

Source files
------------

// File: rtl/switch_nport.sv
// switch_nport: N-port packet switch with one packet FIFO per input,
// a round-robin arbiter per output, multicast delivery and a registered
// output stage that holds under downstream backpressure.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The source may raise valid at any time; ready never
// depends on valid in the same cycle (ready_in is a function of FIFO
// occupancy only).
module switch_nport #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            valid_in,
  output logic [NUM_PORTS-1:0]            ready_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  source_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  target_in,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_PORTS-1:0]            valid_out,
  input  logic [NUM_PORTS-1:0]            ready_out,
  output logic [NUM_PORTS*NUM_PORTS-1:0]  source_out,
  output logic [NUM_PORTS*NUM_PORTS-1:0]  target_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out
);

  localparam int N  = NUM_PORTS;
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_PORTS);

  // Packet storage, one FIFO per input port
  logic [N-1:0]  src_mem [N][FIFO_DEPTH];
  logic [N-1:0]  tgt_mem [N][FIFO_DEPTH];
  logic [DW-1:0] dat_mem [N][FIFO_DEPTH];

  logic [AW-1:0] wr_ptr  [N];
  logic [AW-1:0] rd_ptr  [N];
  logic [AW-1:0] rd_next [N];
  logic [CW-1:0] count   [N];
  logic [N-1:0]  rem     [N];   // outputs still owed by the head packet
  logic [N-1:0]  rem_left[N];   // rem after this cycle's grants

  logic [N-1:0]  head_src[N];
  logic [N-1:0]  head_tgt[N];
  logic [DW-1:0] head_dat[N];

  logic [N-1:0]  empty;
  logic [N-1:0]  full;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;

  logic [PW-1:0] ptr      [N];  // round-robin pointer per output
  logic [N-1:0]  grant    [N];  // grant[o][i]: output o serves input i
  logic [N-1:0]  gmask    [N];  // gmask[i][o]: transpose of grant
  logic [N-1:0]  any_grant;
  logic [PW-1:0] grant_idx[N];

  // FIFO status, head view and ingress acceptance; target==0 is
  // handshaken but never stored
  always_comb begin
    for (int p = 0; p < N; p++) begin
      empty[p]    = (count[p] == '0);
      full[p]     = (count[p] == CW'(FIFO_DEPTH));
      ready_in[p] = !full[p];
      push[p]     = valid_in[p] && !full[p] && (|target_in[p*N +: N]);
      rd_next[p]  = rd_ptr[p] + AW'(1);
      head_src[p] = src_mem[p][rd_ptr[p]];
      head_tgt[p] = tgt_mem[p][rd_ptr[p]];
      head_dat[p] = dat_mem[p][rd_ptr[p]];
    end
  end

  // Per-output round-robin arbitration, first requester at or after ptr
  always_comb begin
    for (int o = 0; o < N; o++) begin
      grant[o]     = '0;
      any_grant[o] = 1'b0;
      grant_idx[o] = '0;
      if (!valid_out[o] || ready_out[o]) begin
        for (int k = 0; k < N; k++) begin
          if (!any_grant[o] && !empty[(int'(ptr[o]) + k) % N] &&
              rem[(int'(ptr[o]) + k) % N][o]) begin
            grant[o][(int'(ptr[o]) + k) % N] = 1'b1;
            any_grant[o] = 1'b1;
            grant_idx[o] = PW'((int'(ptr[o]) + k) % N);
          end
        end
      end
    end
  end

  // Collect grants per input; the head pops once every target is served
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int o = 0; o < N; o++) begin
        gmask[i][o] = grant[o][i];
      end
      rem_left[i] = rem[i] & ~gmask[i];
      pop[i]      = !empty[i] && (|gmask[i]) && (rem_left[i] == '0);
    end
  end

  // Packet payload write; contents are qualified by count, so no reset
  always_ff @(posedge clk) begin
    for (int p = 0; p < N; p++) begin
      if (push[p]) begin
        src_mem[p][wr_ptr[p]] <= source_in[p*N +: N];
        tgt_mem[p][wr_ptr[p]] <= target_in[p*N +: N];
        dat_mem[p][wr_ptr[p]] <= data_in[p*DW +: DW];
      end
    end
  end

  // FIFO pointers, occupancy and the pending-output mask of each head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < N; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
        rem[p]    <= '0;
      end
    end else begin
      for (int p = 0; p < N; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (pop[p])  rd_ptr[p] <= rd_next[p];
        case ({push[p], pop[p]})
          2'b10:   count[p] <= count[p] + CW'(1);
          2'b01:   count[p] <= count[p] - CW'(1);
          default: count[p] <= count[p];
        endcase
        // A new head loads its target the same edge the old one leaves
        if (pop[p]) begin
          if (count[p] > CW'(1))  rem[p] <= tgt_mem[p][rd_next[p]];
          else if (push[p])       rem[p] <= target_in[p*N +: N];
          else                    rem[p] <= '0;
        end else if (empty[p] && push[p]) begin
          rem[p] <= target_in[p*N +: N];
        end else begin
          rem[p] <= rem_left[p];
        end
      end
    end
  end

  // Output registers and arbiter pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < N; o++) ptr[o] <= '0;
      valid_out  <= '0;
      source_out <= '0;
      target_out <= '0;
      data_out   <= '0;
    end else begin
      for (int o = 0; o < N; o++) begin
        if (any_grant[o]) begin
          if (grant_idx[o] == PW'(N - 1)) ptr[o] <= '0;
          else                            ptr[o] <= grant_idx[o] + PW'(1);
          valid_out[o]          <= 1'b1;
          source_out[o*N +: N]  <= head_src[grant_idx[o]];
          target_out[o*N +: N]  <= head_tgt[grant_idx[o]];
          data_out[o*DW +: DW]  <= head_dat[grant_idx[o]];
        end else if (ready_out[o]) begin
          valid_out[o] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_nport.sv
// tb_switch_nport: directed scenarios for the 4-port, 8-bit, depth-4 switch.
module tb_switch_nport;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  valid_in;
  logic [N-1:0]  ready_in;
  logic [N*N-1:0]  source_in;
  logic [N*N-1:0]  target_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  valid_out;
  logic [N-1:0]  ready_out;
  logic [N*N-1:0]  source_out;
  logic [N*N-1:0]  target_out;
  logic [N*DW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       mon_en = 1'b0;

  // Expected service order of output 3 for the three contention bursts
  int         ord  [3][4];
  logic [7:0] base [3];

  switch_nport #(.NUM_PORTS(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in),
    .source_in(source_in), .target_in(target_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .source_out(source_out), .target_out(target_out), .data_out(data_out)
  );

  // Clock
  always #5 clk = ~clk;

  // Output-0 transfer monitor
  always @(posedge clk) begin
    if (mon_en && valid_out[0] && ready_out[0]) got_q.push_back(data_out[7:0]);
  end

  // Time limit
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in  = '0;
    source_in = '0;
    target_in = '0;
    data_in   = '0;
  endtask

  task automatic drive_pkt(input int p, input logic [3:0] tgt, input logic [7:0] d);
    logic [3:0] one;
    one = 4'b0001 << p;
    valid_in[p]          = 1'b1;
    source_in[p*4 +: 4]  = one;
    target_in[p*4 +: 4]  = tgt;
    data_in[p*8 +: 8]    = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    ready_out = 4'hf;
    repeat (3) step();
    checks++; if (valid_out !== 4'b0000) begin errors++; $display("FAIL reset_valid_out got %b exp 0000", valid_out); end
    checks++; if (ready_in !== 4'b1111) begin errors++; $display("FAIL reset_ready_in got %b exp 1111", ready_in); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got %h exp 0", data_out); end
    checks++; if (source_out !== '0) begin errors++; $display("FAIL reset_source_out got %h exp 0", source_out); end
    checks++; if (target_out !== '0) begin errors++; $display("FAIL reset_target_out got %h exp 0", target_out); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unicast();
    ready_out = 4'hf;
    drive_pkt(0, 4'b0100, 8'hA5);
    step();
    idle_inputs();
    checks++; if (valid_out !== 4'b0000) begin errors++; $display("FAIL unicast_early got %b exp 0000", valid_out); end
    step();
    checks++; if (valid_out !== 4'b0100) begin errors++; $display("FAIL unicast_valid got %b exp 0100", valid_out); end
    checks++; if (data_out[23:16] !== 8'hA5) begin errors++; $display("FAIL unicast_data got %h exp a5", data_out[23:16]); end
    checks++; if (source_out[11:8] !== 4'b0001) begin errors++; $display("FAIL unicast_source got %b exp 0001", source_out[11:8]); end
    checks++; if (target_out[11:8] !== 4'b0100) begin errors++; $display("FAIL unicast_target got %b exp 0100", target_out[11:8]); end
    step();
    checks++; if (valid_out !== 4'b0000) begin errors++; $display("FAIL unicast_clear got %b exp 0000", valid_out); end
  endtask

  task automatic test_contention();
    logic [7:0] d;
    logic [3:0] s;
    ready_out = 4'hf;
    for (int r = 0; r < 3; r++) begin
      if (r == 2) begin
        drive_pkt(1, 4'b1000, 8'h50);
        step();
        idle_inputs();
        step();
        checks++;
        if (valid_out[3] !== 1'b1 || source_out[15:12] !== 4'b0010) begin
          errors++; $display("FAIL contention_solo got v=%b src=%b exp v=1 src=0010", valid_out[3], source_out[15:12]);
        end
      end
      for (int i = 0; i < 4; i++) drive_pkt(i, 4'b1000, base[r] + 8'(i));
      step();
      idle_inputs();
      for (int k = 0; k < 4; k++) exp_q.push_back(base[r] + 8'(ord[r][k]));
      for (int k = 0; k < 4; k++) begin
        step();
        d = exp_q.pop_front();
        s = 4'b0001 << ord[r][k];
        checks++;
        if (valid_out[3] !== 1'b1 || source_out[15:12] !== s || data_out[31:24] !== d) begin
          errors++;
          $display("FAIL contention r%0d k%0d got v=%b src=%b data=%h exp v=1 src=%b data=%h",
                   r, k, valid_out[3], source_out[15:12], data_out[31:24], s, d);
        end
      end
      step();
      checks++; if (valid_out[3] !== 1'b0) begin errors++; $display("FAIL contention_idle r%0d got %b exp 0", r, valid_out[3]); end
    end
  endtask

  task automatic test_multicast_stall();
    ready_out = 4'b0011;
    drive_pkt(0, 4'b1000, 8'hB0);
    step();
    idle_inputs();
    drive_pkt(1, 4'b1101, 8'hC1);
    step();
    idle_inputs();
    drive_pkt(1, 4'b0001, 8'hC2);
    step();
    idle_inputs();
    checks++; if (valid_out !== 4'b1101) begin errors++; $display("FAIL mcast_valid got %b exp 1101", valid_out); end
    checks++; if (data_out[7:0] !== 8'hC1) begin errors++; $display("FAIL mcast_data0 got %h exp c1", data_out[7:0]); end
    checks++; if (target_out[3:0] !== 4'b1101) begin errors++; $display("FAIL mcast_target0 got %b exp 1101", target_out[3:0]); end
    checks++; if (source_out[3:0] !== 4'b0010) begin errors++; $display("FAIL mcast_source0 got %b exp 0010", source_out[3:0]); end
    checks++; if (data_out[23:16] !== 8'hC1) begin errors++; $display("FAIL mcast_data2 got %h exp c1", data_out[23:16]); end
    checks++; if (data_out[31:24] !== 8'hB0 || source_out[15:12] !== 4'b0001) begin
      errors++; $display("FAIL mcast_hold3 got data=%h src=%b exp data=b0 src=0001", data_out[31:24], source_out[15:12]);
    end
    step();
    checks++; if (valid_out !== 4'b1100) begin errors++; $display("FAIL mcast_stall_c4 got %b exp 1100", valid_out); end
    step();
    checks++; if (valid_out !== 4'b1100) begin errors++; $display("FAIL mcast_stall_c5 got %b exp 1100", valid_out); end
    ready_out = 4'b1011;
    step();
    checks++; if (valid_out !== 4'b1100) begin errors++; $display("FAIL mcast_port3_grant got %b exp 1100", valid_out); end
    checks++; if (data_out[31:24] !== 8'hC1 || source_out[15:12] !== 4'b0010 || target_out[15:12] !== 4'b1101) begin
      errors++; $display("FAIL mcast_port3_pkt got data=%h src=%b tgt=%b exp data=c1 src=0010 tgt=1101",
                         data_out[31:24], source_out[15:12], target_out[15:12]);
    end
    step();
    checks++; if (valid_out[0] !== 1'b1 || data_out[7:0] !== 8'hC2) begin
      errors++; $display("FAIL mcast_next_head got v=%b data=%h exp v=1 data=c2", valid_out[0], data_out[7:0]);
    end
    checks++; if (valid_out[2] !== 1'b1 || data_out[23:16] !== 8'hC1) begin
      errors++; $display("FAIL mcast_hold2 got v=%b data=%h exp v=1 data=c1", valid_out[2], data_out[23:16]);
    end
    ready_out = 4'hf;
    repeat (3) step();
    checks++; if (valid_out !== 4'b0000) begin errors++; $display("FAIL mcast_drain got %b exp 0000", valid_out); end
  endtask

  task automatic test_backpressure_full();
    int sent;
    logic [7:0] g;
    logic [7:0] e;
    sent = 0;
    exp_q.delete();
    got_q.delete();
    ready_out = 4'b1110;
    idle_inputs();
    mon_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (sent < 6 && ready_in[2]) begin
        drive_pkt(2, 4'b0001, 8'h61 + 8'(sent));
        exp_q.push_back(8'h61 + 8'(sent));
        sent++;
      end else begin
        valid_in[2] = 1'b0;
      end
      step();
    end
    idle_inputs();
    checks++; if (sent !== 5) begin errors++; $display("FAIL full_accepted got %0d exp 5", sent); end
    checks++; if (ready_in[2] !== 1'b0) begin errors++; $display("FAIL full_ready_in got %b exp 0", ready_in[2]); end
    checks++; if (valid_out[0] !== 1'b1 || data_out[7:0] !== 8'h61) begin
      errors++; $display("FAIL full_hold got v=%b data=%h exp v=1 data=61", valid_out[0], data_out[7:0]);
    end
    ready_out = 4'hf;
    for (int c = 0; c < 12; c++) begin
      if (sent < 6 && ready_in[2]) begin
        drive_pkt(2, 4'b0001, 8'h61 + 8'(sent));
        exp_q.push_back(8'h61 + 8'(sent));
        sent++;
      end else begin
        valid_in[2] = 1'b0;
      end
      step();
    end
    idle_inputs();
    mon_en = 1'b0;
    checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL full_count got %0d exp 6", got_q.size()); end
    for (int k = 0; k < 6; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL full_order k%0d got %h exp %h", k, g, e); end
    end
  endtask

  task automatic test_drop();
    ready_out = 4'hf;
    checks++; if (ready_in[3] !== 1'b1) begin errors++; $display("FAIL drop_ready_before got %b exp 1", ready_in[3]); end
    drive_pkt(3, 4'b0000, 8'hEE);
    step();
    idle_inputs();
    checks++; if (ready_in[3] !== 1'b1) begin errors++; $display("FAIL drop_ready_after got %b exp 1", ready_in[3]); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (valid_out !== 4'b0000) begin errors++; $display("FAIL drop_no_output c%0d got %b exp 0000", c, valid_out); end
    end
    drive_pkt(3, 4'b0001, 8'h3C);
    step();
    idle_inputs();
    step();
    checks++; if (valid_out !== 4'b0001 || data_out[7:0] !== 8'h3C || source_out[3:0] !== 4'b1000) begin
      errors++; $display("FAIL drop_followup got v=%b data=%h src=%b exp v=0001 data=3c src=1000",
                         valid_out, data_out[7:0], source_out[3:0]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    ready_out = 4'b0000;
    for (int i = 0; i < 4; i++) drive_pkt(i, 4'b0010, 8'h70 + 8'(i));
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      drive_pkt(3, 4'b0010, 8'h74 + 8'(c));
      step();
      idle_inputs();
    end
    checks++; if (ready_in !== 4'b0111) begin errors++; $display("FAIL rstmid_pre_ready got %b exp 0111", ready_in); end
    checks++; if (valid_out !== 4'b0010 || source_out[7:4] !== 4'b0001) begin
      errors++; $display("FAIL rstmid_pre_out got v=%b src=%b exp v=0010 src=0001", valid_out, source_out[7:4]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (valid_out !== 4'b0000) begin errors++; $display("FAIL rstmid_valid got %b exp 0000", valid_out); end
    checks++; if (ready_in !== 4'b1111) begin errors++; $display("FAIL rstmid_ready got %b exp 1111", ready_in); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_out = 4'hf;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (valid_out !== 4'b0000) begin errors++; $display("FAIL rstmid_stale c%0d got %b exp 0000", c, valid_out); end
    end
    drive_pkt(0, 4'b0010, 8'h80);
    drive_pkt(3, 4'b0010, 8'h83);
    step();
    idle_inputs();
    step();
    checks++; if (valid_out[1] !== 1'b1 || source_out[7:4] !== 4'b0001 || data_out[15:8] !== 8'h80) begin
      errors++; $display("FAIL rstmid_ptr_first got v=%b src=%b data=%h exp v=1 src=0001 data=80",
                         valid_out[1], source_out[7:4], data_out[15:8]);
    end
    step();
    checks++; if (valid_out[1] !== 1'b1 || source_out[7:4] !== 4'b1000 || data_out[15:8] !== 8'h83) begin
      errors++; $display("FAIL rstmid_ptr_second got v=%b src=%b data=%h exp v=1 src=1000 data=83",
                         valid_out[1], source_out[7:4], data_out[15:8]);
    end
    step();
  endtask

  initial begin
    ord[0] = '{0, 1, 2, 3};
    ord[1] = '{0, 1, 2, 3};
    ord[2] = '{2, 3, 0, 1};
    base[0] = 8'h30;
    base[1] = 8'h40;
    base[2] = 8'h58;
    test_reset();
    test_unicast();
    test_contention();
    test_multicast_stall();
    test_backpressure_full();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
